// File: rtl/cpu_lab_pkg.sv
// Shared types and constants for the CPU lab program loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state to the loader FSM.
package cpu_lab_pkg;

  localparam int unsigned IMEM_DEPTH_DEFAULT = 32;
  localparam logic [31:0] TERM_WORD          = 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone,
    StErr
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    StCsum
`endif
  } loader_state_e;

  // Byte order: the first byte received ends up in bits [31:24].
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// 8-to-32 MSB-first shift register; flags the word on its 4th byte.
module byte_packer
  import cpu_lab_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] word_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (valid_i) begin
      word_q  <= shift_in_byte(word_q, data_i);
      count_q <= count_q + 2'd1;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_i && (count_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory and holds the CPU in reset until an all-zero word.
// Defining IMEM_LOADER_CHECKSUM_EN appends a one-byte XOR checksum after the terminator.
module imem_loader
  import cpu_lab_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [31:0]       word;
  logic              word_valid;
  logic              accept;
  logic              load_byte;
  logic              arm;
  logic              is_term;
  logic              last_addr;

  assign accept    = s_valid_i && s_ready_o;
  assign load_byte = accept && (state_q == StLoad);
  assign arm       = start_i && (state_q inside {StIdle, StDone, StErr});
  assign is_term   = (word == TERM_WORD);
  assign last_addr = (addr_q == ADDR_W'(IMEM_DEPTH - 1));

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (arm),
    .valid_i      (load_byte),
    .data_i       (s_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else if (arm) begin
      csum_q <= '0;
    end else if (load_byte) begin
      csum_q <= csum_q ^ s_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        if (word_valid) state_d = StWrite;
      end
      StWrite: begin
        if (is_term) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else if (last_addr) begin
          // No slot left for the terminator.
          state_d = StErr;
        end else begin
          state_d = StLoad;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = (s_data_i == csum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    words_d = words_q;
    if (arm) begin
      addr_d  = '0;
      words_d = '0;
    end else if (state_q == StWrite) begin
      words_d = words_q + (ADDR_W + 1)'(1);
      if (!is_term && !last_addr) addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    s_ready_o   = 1'b0;
    im_we_o     = 1'b0;
    cpu_rst_n_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      StLoad:  s_ready_o = 1'b1;
      StWrite: im_we_o   = 1'b1;
      StDone: begin
        cpu_rst_n_o = 1'b1;
        done_o      = 1'b1;
      end
      StErr:   err_o     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum:  s_ready_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign im_addr_o  = addr_q;
  assign im_wdata_o = word;
  assign words_o    = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of programs plus hand-written corner cases.
module tb_imem_loader;

  localparam int unsigned Depth = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst_n;
  logic          done;
  logic          err;
  logic [AW:0]   words;

  always #5 clk = ~clk;

  imem_loader #(
    .IMEM_DEPTH (Depth)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready),
    .im_we_o     (im_we),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .cpu_rst_n_o (cpu_rst_n),
    .done_o      (done),
    .err_o       (err),
    .words_o     (words)
  );

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [2:0]       n;
    logic             toggle;
    logic             exp_err;
    logic [2:0]       exp_words;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  exp_addr;
  logic [7:0]     csum_x;
  int             accepts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every write must match the scoreboard and follow exactly 4 accepts.
  initial begin
    accepts = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        accepts = 0;
      end else begin
        if (start && !s_ready && !im_we) accepts = 0;
        if (im_we) begin
          check("write_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check("write_addr_data", {im_addr, im_wdata}, exp_q.pop_front());
          check("accepts_per_write", accepts, 4);
          accepts = 0;
        end
        if (s_valid && s_ready) accepts++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [2:0] n, input logic tg, input logic e,
                              input logic [2:0] nw);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.n = n; v.toggle = tg; v.exp_err = e; v.exp_words = nw;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    bit acc;
    if (toggle) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    csum_x  = csum_x ^ b;
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], toggle);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic arm();
    pulse_start();
    exp_addr = '0;
    csum_x   = '0;
    check("arm_ready", s_ready, 1);
    check("arm_cpu_held", cpu_rst_n, 0);
    check("arm_done_low", done, 0);
    check("arm_err_low", err, 0);
    check("arm_words_clear", words, 0);
  endtask

  // Called right after the last data byte was accepted (DUT now in its final WRITE).
  task automatic finish_load(input bit exp_err, input logic [2:0] exp_words);
    @(negedge clk);
    check("last_write_we", im_we, 1);
    check("cpu_held_in_write", cpu_rst_n, 0);
    check("done_low_in_write", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!exp_err) send_byte(csum_x, 1'b0);
`endif
    @(negedge clk);
    check("final_done", done, !exp_err);
    check("final_cpu_rst_n", cpu_rst_n, !exp_err);
    check("final_err", err, exp_err);
    check("final_words", words, exp_words);
    check("final_ready", s_ready, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = mk(32'h20010005, 32'h0, 32'h0, 32'h0, 3'd2, 1'b0, 1'b0, 3'd2);
    vecs[1] = mk(32'h20010005, 32'h0, 32'h0, 32'h0, 3'd2, 1'b1, 1'b0, 3'd2);
    vecs[2] = mk(32'h0, 32'h0, 32'h0, 32'h0, 3'd1, 1'b0, 1'b0, 3'd1);
    vecs[3] = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                 3'd4, 1'b0, 1'b1, 3'd4);
    vecs[4] = mk(32'hdeadbeef, 32'h00000001, 32'h80000000, 32'h0, 3'd4, 1'b1, 1'b0, 3'd4);

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    exp_addr = '0; csum_x = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 0);
    check("rst_we", im_we, 0);
    check("rst_addr", im_addr, 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", s_ready, 0);
    check("idle_cpu_held", cpu_rst_n, 0);

    for (int v = 0; v < 5; v++) begin
      arm();
      for (int k = 0; k < int'(vecs[v].n); k++) send_word(vecs[v].w[k], vecs[v].toggle);
      finish_load(vecs[v].exp_err, vecs[v].exp_words);
    end

    // Asynchronous reset two bytes into the second word.
    arm();
    send_word(32'ha5a5a5a5, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("midrst_ready", s_ready, 0);
    check("midrst_we", im_we, 0);
    check("midrst_addr", im_addr, 0);
    check("midrst_wdata", im_wdata, 0);
    check("midrst_cpu_rst_n", cpu_rst_n, 0);
    check("midrst_words", words, 0);
    check("midrst_no_pending", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    arm();
    send_word(32'h12345678, 1'b0);
    send_word(32'h0, 1'b0);
    finish_load(1'b0, 3'd2);

    // start_i pulsed during WRITE and LOAD must not restart the load.
    arm();
    send_word(32'h0badf00d, 1'b0);
    pulse_start();
    check("start_in_write_ignored", words, 1);
    send_byte(8'h11, 1'b0);
    pulse_start();
    check("start_in_load_ignored", s_ready, 1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    exp_q.push_back({exp_addr, 32'h11223344});
    exp_addr = exp_addr + 1'b1;
    send_word(32'h0, 1'b0);
    finish_load(1'b0, 3'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum after 01 02 03 04 / 00 00 00 00 (correct value is 04).
    arm();
    send_word(32'h01020304, 1'b0);
    send_word(32'h0, 1'b0);
    @(negedge clk);
    send_byte(8'h05, 1'b0);
    @(negedge clk);
    check("csum_bad_err", err, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_cpu_held", cpu_rst_n, 0);
    arm();
    send_word(32'h01020304, 1'b0);
    send_word(32'h0, 1'b0);
    @(negedge clk);
    send_byte(8'h04, 1'b0);
    @(negedge clk);
    check("csum_good_done", done, 1);
    check("csum_good_err", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the single-cycle CPU. It accepts a byte stream over a valid/ready handshake, packs the bytes MSB-first into 32-bit instruction words, and writes them sequentially into instruction memory starting at word 0. While loading, it holds the CPU in reset. Loading ends at an all-zero terminator word, which is also the end-of-program convention, and the CPU is then released. It sits between a host or UART byte source and the `Instr_Mem` write port, upstream of the CPU's `rst_n`.

## Interface
- `IMEM_DEPTH`, default 32: instruction memory depth in words.
- `ADDR_W`, default `$clog2(IMEM_DEPTH)`: width of the word address.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `start_i`, in, 1: single-cycle pulse that arms a new load.
- `s_valid_i`, in, 1: the byte source has a byte available.
- `s_data_i`, in, 8: stream byte.
- `s_ready_o`, out, 1: the loader accepts a byte this cycle.
- `im_we_o`, out, 1: instruction memory write enable.
- `im_addr_o`, out, `ADDR_W`: word address for the write.
- `im_wdata_o`, out, 32: instruction word to write.
- `cpu_rst_n_o`, out, 1: active-low CPU reset; 0 holds the CPU in reset.
- `done_o`, out, 1: load completed and the CPU is running.
- `err_o`, out, 1: load failed.
- `words_o`, out, `ADDR_W+1`: number of words written, including the terminator.

## Operation
- FSM states: `IDLE`, `LOAD`, `WRITE`, `DONE`, `ERR`.
- **`IDLE`:** `s_ready_o`=0 and `cpu_rst_n_o`=0. `start_i` moves to `LOAD` and clears the address, byte counter and `words_o`.
- **`LOAD`:** `s_ready_o`=1.
  - A byte is accepted on each cycle where `s_valid_i` and `s_ready_o` are both high.
  - Each accepted byte shifts in as `word = {word[23:0], byte}`, so the first byte becomes bits [31:24].
  - The 4th accepted byte moves the FSM to `WRITE`.
- **`WRITE`:** lasts exactly 1 cycle.
  - Outputs: `im_we_o`=1, `im_addr_o`=current address, `im_wdata_o`=packed word, `s_ready_o`=0. `words_o` increments.
  - If the word is 0: go to `DONE` (or to the checksum phase, see Configuration).
  - Else, if the address is `IMEM_DEPTH-1`: go to `ERR`, because there is no room for a terminator.
  - Else: increment the address and return to `LOAD`.
- **`DONE`:** `cpu_rst_n_o`=1, `done_o`=1, `s_ready_o`=0. `start_i` re-arms the load: go to `LOAD` with `cpu_rst_n_o`=0 in the next cycle.
- **`ERR`:** `err_o`=1 and `cpu_rst_n_o`=0. `start_i` re-arms the load and clears `err_o`.
- `start_i` is ignored in `LOAD` and `WRITE`.
- Bytes presented while `s_ready_o`=0 are not consumed, so the source must hold them.
- Memory contents above the terminator are not touched.

## Timing
- **Reset values:** state `IDLE`; all outputs 0, which means `cpu_rst_n_o`=0.
- Asynchronous assert of `rst_i` mid-load returns immediately to `IDLE`. Partial words are discarded and the CPU stays in reset.
- **Per-word latency:** 4 accept cycles plus 1 `WRITE` cycle, so at most one word per 5 cycles. The byte counter wraps at 4.
- `cpu_rst_n_o` rises on the first clock edge after the terminator's `WRITE` cycle. `done_o` rises on that same edge.
- `im_we_o` is never asserted outside `WRITE`.
- `im_addr_o` and `im_wdata_o` are registered outputs, stable throughout `WRITE`.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - After the terminator write, the FSM enters state `CSUM` with `s_ready_o`=1 and accepts exactly one byte.
  - That byte is compared with the XOR of all previously accepted bytes, terminator bytes included.
  - On a match go to `DONE`; on a mismatch go to `ERR`.
- **Not defined:** state `CSUM` does not exist, and the terminator goes directly to `DONE`.

## Structure
- **Shared package `cpu_lab_pkg`:** loader state enum, the `IMEM_DEPTH` default, the `TERM_WORD` constant (32'h0), and the byte-order definition.
- **Sub-module `byte_packer`:** 8→32 MSB-first shift register with a 2-bit count. It outputs `word_valid` on the 4th byte and has a `clear` input.

## Test plan
- Reset, then `start_i`, then stream bytes 20 01 00 05 / 00 00 00 00 → memory[0]=0x20010005 and memory[1]=0. `done_o`=1 and `cpu_rst_n_o`=1 on the cycle after the second `WRITE`. `words_o`=2.
- The same stream with `s_valid_i` toggled every other cycle → identical memory contents. `WRITE` cycles are separated by at least 4 accepts.
- With `IMEM_DEPTH`=4, stream 4 non-zero words → `ERR`, `err_o`=1, `cpu_rst_n_o`=0, `words_o`=4. `start_i` plus a valid program then recovers to `DONE`.
- Assert `rst_i` after 2 bytes of word 1 → immediate `IDLE` with all outputs 0. After a new `start_i`, the load restarts at address 0.
- `start_i` pulsed during `LOAD` → ignored, and the address keeps incrementing.
- With `IMEM_LOADER_CHECKSUM_EN`: bytes 01 02 03 04 00 00 00 00, then checksum 0x04 → `DONE`. Checksum 0x05 → `ERR`.
